tick_timer_scheduler: RTL and testbench

Shared timeout scheduler built around a single prescaled tick. It divides the 100 MHz board clock into a periodic one-cycle tick and multiplexes that tick across NCH independent countdown channels. Requesters are the ATM control FSMs, for example PIN-entry timeout, card-eject timeout and display hold. They arm a channel through a round-robin req/gnt handshake and receive a one-cycle expire pulse.

---
 rtl/tick_timer_scheduler.sv | 148 ++++++++++++++
 tb/tb_tick_timer_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_scheduler.sv
// tick_timer_scheduler: prescaled tick shared by NCH countdown channels,
// armed through a round-robin req/gnt handshake, one-cycle expire pulses.
//
// Ports:
//   clk_in    system clock
//   rst_n     asynchronous active-low reset
//   pause     (only with TICK_TIMER_PAUSE_EN) freezes prescaler and countdown
//   req       per-channel arm request, held until gnt seen
//   load_val  channel i duration in ticks at [i*CNT_W +: CNT_W]
//   cancel    per-channel disarm, level-sampled
//   gnt       one-hot registered grant, one cycle
//   busy      channel armed
//   expire    one-cycle registered timeout pulse
//   tick_out  one-cycle tick every CLK_DIV cycles
//
// Optional feature macro: TICK_TIMER_PAUSE_EN (adds the pause input).
module tick_timer_scheduler #(
    parameter int CLK_DIV = 1000000,
    parameter int NCH     = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
`ifdef TICK_TIMER_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic [NCH-1:0]       req,
    input  logic [NCH*CNT_W-1:0] load_val,
    input  logic [NCH-1:0]       cancel,
    output logic [NCH-1:0]       gnt,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       expire,
    output logic                 tick_out
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_st_t;

    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic [RW-1:0]    r_rr;
    logic [NCH-1:0]   r_gnt;
    logic [NCH-1:0]   r_exp;
    ch_st_t           r_st  [NCH];
    logic [CNT_W-1:0] r_cnt [NCH];

    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_gnt;
    logic [RW-1:0]    w_rr_nxt;
    logic [RW-1:0]    w_sel;
    logic             w_found;

    // Prescaler: phase is never reset by arming, so a channel's
    // effective duration lies between L-1 and L tick periods.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end
`ifdef TICK_TIMER_PAUSE_EN
        else if (pause) begin
            r_tick <= 1'b0;
        end
`endif
        else if (r_presc == LAST) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    // Round-robin search from r_rr. The registered grant masks a
    // requester that still holds req in its grant cycle.
    always_comb begin
        w_elig   = req & ~cancel & ~r_gnt;
        w_gnt    = '0;
        w_rr_nxt = r_rr;
        w_found  = 1'b0;
        w_sel    = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sel = RW'((int'(r_rr) + i) % NCH);
            if (!w_found && w_elig[w_sel]) begin
                w_found      = 1'b1;
                w_gnt[w_sel] = 1'b1;
                w_rr_nxt     = RW'((int'(w_sel) + 1) % NCH);
            end
        end
    end

    // Channel FSMs. Priority: cancel, then (re-)arm, then expiry.
    // A zero count in ARMED only arises from load_val = 0 and
    // expires on the next edge regardless of the tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= '0;
            r_exp <= '0;
            r_rr  <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_st[k]  <= IDLE;
                r_cnt[k] <= '0;
            end
        end else begin
            r_gnt <= w_gnt;
            r_rr  <= w_rr_nxt;
            for (int k = 0; k < NCH; k++) begin
                r_exp[k] <= 1'b0;
                if (cancel[k]) begin
                    r_st[k]  <= IDLE;
                    r_cnt[k] <= '0;
                end else if (w_gnt[k]) begin
                    r_st[k]  <= ARMED;
                    r_cnt[k] <= load_val[k*CNT_W +: CNT_W];
                end else if (r_st[k] == ARMED) begin
                    if (r_cnt[k] == '0) begin
                        r_st[k]  <= IDLE;
                        r_exp[k] <= 1'b1;
                    end else if (r_tick) begin
                        r_cnt[k] <= r_cnt[k] - 1'b1;
                        if (r_cnt[k] == CNT_W'(1)) begin
                            r_st[k]  <= IDLE;
                            r_exp[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < NCH; k++) begin
            busy[k] = (r_st[k] == ARMED);
        end
    end

    assign gnt      = r_gnt;
    assign expire   = r_exp;
    assign tick_out = r_tick;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Randomized scoreboard bench for tick_timer_scheduler.
// Driver predicts grants/expiries from the arbitration and tick rules.
module tb_tick_timer_scheduler;

    localparam int CLK_DIV = 10;
    localparam int NCH     = 4;
    localparam int CNT_W   = 8;

    logic                 clk_in = 1'b0;
    logic                 rst_n  = 1'b0;
    logic [NCH-1:0]       req    = '0;
    logic [NCH*CNT_W-1:0] load_val = '0;
    logic [NCH-1:0]       cancel = '0;
    logic [NCH-1:0]       gnt;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       expire;
    logic                 tick_out;
`ifdef TICK_TIMER_PAUSE_EN
    logic                 pause = 1'b0;
`endif

    tick_timer_scheduler #(
        .CLK_DIV (CLK_DIV),
        .NCH     (NCH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
`ifdef TICK_TIMER_PAUSE_EN
        .pause    (pause),
`endif
        .req      (req),
        .load_val (load_val),
        .cancel   (cancel),
        .gnt      (gnt),
        .busy     (busy),
        .expire   (expire),
        .tick_out (tick_out)
    );

    always #5 clk_in = ~clk_in;

    // Edge count since reset release; cycle E = state after edge E.
    int cyc;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int e;
        int ch;
    } gev_t;

    gev_t gq[$];
    int   xq[NCH][$];

    logic [NCH-1:0] pend;
    logic [NCH-1:0] lastg;
    int             ptr;
    int             lv [NCH];

    bit drv_en = 0;
    bit mon_en = 0;
    bit quiet  = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d",
                      nm, cyc, act, exp);
    endtask

    // Expiry edge: L = 0 -> next edge; else one edge after the L-th
    // tick_out cycle at or after the grant edge.
    function automatic int xedge(int g, int l);
        int t1;
        if (l == 0) return g + 1;
        t1 = ((g + CLK_DIV - 1) / CLK_DIV) * CLK_DIV;
        return t1 + (l - 1) * CLK_DIV + 1;
    endfunction

    task automatic drive_step();
        int             e1;
        logic [NCH-1:0] c;
        logic [NCH-1:0] elig;
        bit             found;
        int             j;
        if (!rst_n) begin
            gq.delete();
            for (int k = 0; k < NCH; k++) begin
                xq[k].delete();
                lv[k] = 0;
            end
            pend   = '0;
            lastg  = '0;
            ptr    = 0;
            req    = '0;
            cancel = '0;
            return;
        end
        e1 = cyc + 1;
        c  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!quiet) begin
                if (!pend[k] && $urandom_range(0, 5) == 0) begin
                    pend[k] = 1'b1;
                    lv[k]   = int'($urandom_range(0, 5));
                end
                if (xq[k].size() > 0 && xq[k][0] == e1
                    && $urandom_range(0, 1) == 1)
                    c[k] = 1'b1;
                else if ($urandom_range(0, 39) == 0)
                    c[k] = 1'b1;
            end
            load_val[k*CNT_W +: CNT_W] = CNT_W'(lv[k]);
        end
        req    = pend;
        cancel = c;
        for (int k = 0; k < NCH; k++)
            if (c[k]) xq[k].delete();
        elig  = pend & ~c & ~lastg;
        lastg = '0;
        found = 0;
        for (int i = 0; i < NCH; i++) begin
            j = (ptr + i) % NCH;
            if (!found && elig[j]) begin
                found    = 1;
                gq.push_back('{e1, j});
                ptr      = (j + 1) % NCH;
                pend[j]  = 1'b0;
                lastg[j] = 1'b1;
                xq[j].delete();
                xq[j].push_back(xedge(e1, lv[j]));
            end
        end
    endtask

    task automatic monitor_step();
        gev_t g;
        int   w;
        int   ex;
        if (!rst_n) begin
            chk("rst_gnt",    int'(gnt),      0);
            chk("rst_busy",   int'(busy),     0);
            chk("rst_expire", int'(expire),   0);
            chk("rst_tick",   int'(tick_out), 0);
            return;
        end
        chk("tick", int'(tick_out),
            int'(cyc > 0 && cyc % CLK_DIV == 0));
        w = 0;
        if (gq.size() > 0 && gq[0].e <= cyc) begin
            g = gq.pop_front();
            w = 1 << g.ch;
        end
        chk("gnt", int'(gnt), w);
        for (int k = 0; k < NCH; k++) begin
            ex = 0;
            if (xq[k].size() > 0 && xq[k][0] <= cyc) begin
                void'(xq[k].pop_front());
                ex = 1;
            end
            chk($sformatf("expire%0d", k), int'(expire[k]), ex);
            chk($sformatf("busy%0d", k), int'(busy[k]),
                int'(xq[k].size() > 0));
        end
    endtask

    initial forever begin
        @(negedge clk_in);
        #1;
        if (drv_en) drive_step();
    end

    initial forever begin
        @(negedge clk_in);
        if (mon_en) monitor_step();
    end

    initial begin
        mon_en = 1;
        drv_en = 1;
        repeat (3) @(negedge clk_in);
        #2 rst_n = 1'b1;
        repeat (1500) @(negedge clk_in);
        @(posedge clk_in);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        #2 rst_n = 1'b1;
        repeat (1500) @(negedge clk_in);
        quiet = 1;
        repeat (150) @(negedge clk_in);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
